fix_add_arb: RTL and testbench
==============================

// Module: fix_add_arb
// PURPOSE
//  Shares one 32-bit signed fixed-point adder (fix_add) among NREQ requesters.
//  Round-robin arbiter picks one pending request, adds a+b, and registers the
//  result in a 1-deep output stage. The output carries the winner's id.
//  Sits between the c2w compute lanes and the single shared adder resource.
// PARAMETERS
//  NREQ   4  number of requesters, 2..8
//  IDW    2  id width, clog2(NREQ)
//  SAT    1  1: saturate on signed overflow; 0: two's-complement wrap
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          synchronous reset, active low
//  req_valid  in   NREQ       per-requester request valid
//  req_a      in   NREQ*32    operand a, requester i at [32*i+31:32*i], signed
//  req_b      in   NREQ*32    operand b, same packing, signed
//  req_ready  out  NREQ       one-hot grant; request i accepted when valid&ready
//  out_valid  out  1          result register holds a valid result
//  out_ready  in   1          downstream accepts the result
//  out_sum    out  32         registered signed sum
//  out_id     out  IDW        index of the requester that produced out_sum
//  out_ovf    out  1          signed overflow on this sum (wrap or clamp)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, out_sum=0, out_id=0, out_ovf=0,
//   rr_ptr=0. req_ready is combinational and is 0 while rst_n=0.
//  Slot free: can_load = !out_valid | out_ready (drain and refill in one cycle).
//  Arbitration (combinational): search i = rr_ptr, rr_ptr+1, ... mod NREQ;
//   the first i with req_valid[i]=1 wins. req_ready = onehot(win) & can_load.
//   If no request is valid, or can_load=0, req_ready=0.
//  Transfer: at posedge with can_load & |req_valid:
//   out_sum <= f(a_win + b_win); out_id <= win; out_ovf <= ovf; out_valid <= 1;
//   rr_ptr <= (win==NREQ-1) ? 0 : win+1.
//  Drain only (out_valid & out_ready & no request valid): out_valid <= 0;
//   out_sum, out_id and out_ovf hold their values.
//  Stall (out_valid & !out_ready): out_* held stable; rr_ptr held; no grant.
//  Latency: 1 cycle from accept to out_valid. Throughput: 1 result per cycle.
//  Arithmetic: 33-bit sum s = sext(a)+sext(b); ovf = s[32]^s[31].
//   SAT=1 and ovf: clamp to 32'h7FFFFFFF if s[32]=0, else 32'h80000000.
//   SAT=0: out_sum = s[31:0]. out_ovf is reported in both modes.
//  Requesters must hold valid/a/b stable until accepted; the arbiter does not
//   latch operands before the grant.
//  Reset mid-operation: any pending result is dropped (out_valid=0) and
//   fairness restarts from requester 0.
//  rr_ptr only advances on a transfer; idle cycles do not rotate priority.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0,
//     out_valid=0, out_sum=0.
//  T2 single: req0 a=5 b=-7, out_ready=1 -> next cycle out_sum=-2, out_id=0,
//     out_ovf=0.
//  T3 fairness: all 4 valid every cycle, out_ready=1 -> out_id sequence
//     0,1,2,3,0,... with no gaps.
//  T4 overflow: a=32'h7FFFFFF0 b=32'h20 -> SAT=1: out_sum=32'h7FFFFFFF,
//     out_ovf=1; SAT=0: out_sum=32'h80000010, out_ovf=1.
//     a=32'h80000000 b=-1 with SAT=1 -> out_sum=32'h80000000, out_ovf=1.
//  T5 backpressure: out_ready=0 for 3 cycles while req2 is valid -> out_*
//     held stable and req_ready=0; when out_ready=1, drain and load the req2
//     result in the same cycle.
//  T6 mid-op reset: assert rst_n=0 while out_valid=1 -> out_valid=0 next cycle;
//     after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fix_add_arb.sv
// Round-robin arbiter sharing one 32-bit signed fixed-point adder among NREQ
// requesters, with a 1-deep registered result stage tagged by the winner's id.
module fix_add_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int SAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_sum,
  output logic [IDW-1:0]       out_id,
  output logic                 out_ovf
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_next;
  logic           found;
  logic           can_load;
  logic [31:0]    a_arr [NREQ];
  logic [31:0]    b_arr [NREQ];
  logic [31:0]    a_sel;
  logic [31:0]    b_sel;
  logic [32:0]    sum_wide;
  logic           ovf;
  logic [31:0]    sum_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  assign can_load = !out_valid || out_ready;

  // Search starting at rr_ptr, wrapping at NREQ, first valid requester wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_l;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_l = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = IDW'(idx);
      if (!found && req_valid[idx_l]) begin
        found = 1'b1;
        win   = idx_l;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && can_load && found) req_ready[win] = 1'b1;
  end

  assign a_sel    = a_arr[win];
  assign b_sel    = b_arr[win];
  assign sum_wide = {a_sel[31], a_sel} + {b_sel[31], b_sel};
  assign ovf      = sum_wide[32] ^ sum_wide[31];
  assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

  always_comb begin
    sum_next = sum_wide[31:0];
    if (SAT != 0 && ovf) sum_next = sum_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= '0;
      out_ovf   <= 1'b0;
      rr_ptr    <= '0;
    end else if (can_load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_sum   <= sum_next;
        out_id    <= win;
        out_ovf   <= ovf;
        rr_ptr    <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fix_add_arb.sv
// Self-checking bench for fix_add_arb: a saturating and a wrapping instance
// share stimulus; a reference arbiter plus result queue checks every cycle.
module tb_fix_add_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         out_ready;

  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_sum;
  logic [1:0]   out_id;
  logic         out_ovf;

  logic [3:0]   w_req_ready;
  logic         w_out_valid;
  logic [31:0]  w_out_sum;
  logic [1:0]   w_out_id;
  logic         w_out_ovf;

  fix_add_arb #(.NREQ(4), .IDW(2), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .out_ovf(out_ovf)
  );

  fix_add_arb #(.NREQ(4), .IDW(2), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(w_req_ready), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_sum(w_out_sum), .out_id(w_out_id), .out_ovf(w_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sat;
    logic [31:0] wrap;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sat;
    logic [31:0] wrap;
    int          id;
    logic        ovf;
  } exp_t;

  vec_t tbl [8];
  exp_t q [$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  logic m_ov   = 1'b0;
  bit   use_tbl = 1'b0;
  vec_t tbl_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int id);
    exp_t        m;
    logic [32:0] s;
    s     = {a[31], a} + {b[31], b};
    m.ovf = s[32] ^ s[31];
    m.wrap = s[31:0];
    m.sat = m.ovf ? (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s[31:0];
    m.id  = id;
    return m;
  endfunction

  // One clock: check grant and output against the model, update it, advance.
  task automatic cycle();
    int         g;
    logic       can;
    logic [3:0] expr;
    exp_t       e;
    #2;
    can  = !m_ov || out_ready;
    g    = -1;
    expr = 4'b0;
    if (rst_n && can) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) expr[g] = 1'b1;
    check("req_ready", {28'b0, req_ready}, {28'b0, expr});
    check("w_req_ready", {28'b0, w_req_ready}, {28'b0, expr});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("w_out_valid", {31'b0, w_out_valid}, {31'b0, m_ov});
    if (rst_n && m_ov) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got out_valid=1 required empty at %0t", $time);
      end else begin
        check("out_sum", out_sum, q[0].sat);
        check("out_id", {30'b0, out_id}, q[0].id);
        check("out_ovf", {31'b0, out_ovf}, {31'b0, q[0].ovf});
        check("w_out_sum", w_out_sum, q[0].wrap);
        check("w_out_id", {30'b0, w_out_id}, q[0].id);
        check("w_out_ovf", {31'b0, w_out_ovf}, {31'b0, q[0].ovf});
        $display("txn id=%0d sum=%h wrap=%h ovf=%0d", out_id, out_sum, w_out_sum, out_ovf);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (g >= 0) begin
      if (use_tbl) begin
        e.sat = tbl_cur.sat; e.wrap = tbl_cur.wrap; e.id = g; e.ovf = tbl_cur.ovf;
      end else begin
        e = model(req_a[32*g +: 32], req_b[32*g +: 32], g);
      end
      q.push_back(e);
    end
    if (!rst_n) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      q.delete();
    end else if (can) begin
      m_ov = (g >= 0);
      if (g >= 0) m_ptr = (g + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{0, 32'd5,          -32'sd7,      32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0};
    tbl[1] = '{1, 32'h7FFF_FFF0, 32'h0000_0020, 32'h7FFF_FFFF, 32'h8000_0010, 1'b1};
    tbl[2] = '{2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    tbl[3] = '{3, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    tbl[4] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    tbl[5] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[6] = '{2, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[7] = '{1, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with every request valid: no grants, cleared outputs.
    cycle();
    cycle();
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_id", {30'b0, out_id}, 32'h0);
    check("rst_out_ovf", {31'b0, out_ovf}, 32'h0);
    rst_n     = 1'b1;
    req_valid = 4'h0;

    // Table vectors: one requester at a time, back-to-back.
    use_tbl = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tbl_cur   = tbl[n];
      req_valid = 4'h0;
      req_valid[tbl[n].idx] = 1'b1;
      req_a[32*tbl[n].idx +: 32] = tbl[n].a;
      req_b[32*tbl[n].idx +: 32] = tbl[n].b;
      cycle();
    end
    use_tbl   = 1'b0;
    req_valid = 4'h0;
    cycle();

    // Fairness from a fresh pointer: grants rotate 0,1,2,3 with no gaps.
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      logic [3:0] want;
      want = 4'b0;
      want[k % 4] = 1'b1;
      #1;
      check("fair_grant", {28'b0, req_ready}, {28'b0, want});
      cycle();
      req_a[32*(k % 4) +: 32] = $urandom;
      req_b[32*(k % 4) +: 32] = $urandom;
    end
    req_valid = 4'h0;
    cycle();

    // Backpressure: result held for 3 cycles, then drain and refill at once.
    req_valid = 4'b0001;
    req_a[31:0] = 32'd100;
    req_b[31:0] = 32'd23;
    cycle();
    req_valid = 4'b0100;
    req_a[95:64] = 32'h1234_5678;
    req_b[95:64] = 32'h0000_0008;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_sum_held", out_sum, 32'd123);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    req_valid = 4'h0;
    check("bp_refill_id", {30'b0, out_id}, 32'd2);
    check("bp_refill_sum", out_sum, 32'h1234_5680);
    cycle();
    cycle();

    // Reset while a result is pending drops it and restarts fairness at 0.
    req_valid = 4'b0010;
    req_a[63:32] = 32'd9;
    req_b[63:32] = 32'd1;
    out_ready = 1'b0;
    cycle();
    req_valid = 4'b1010;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("midrst_grant", {28'b0, req_ready}, 32'b0010);
    cycle();
    req_valid = 4'h0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
